// File: rtl/radix4_booth_ctrl.sv
// Sequencing controller for an iterative radix-4 Booth multiplier datapath.
// Accepts one operand pair, steps the datapath WIDTH/2 times, then holds the product.
module radix4_booth_ctrl #(
  parameter int WIDTH       = 8,
  parameter int CHECK_PARAM = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_multiplier,
  input  logic [WIDTH-1:0]   in_multiplicand,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic               busy,
  output logic               dp_start,
  output logic               dp_en,
  output logic               dp_rst_cntr_n,
  output logic [WIDTH-1:0]   dp_multiplier,
  output logic [WIDTH-1:0]   dp_multiplicand,
  input  logic [2*WIDTH-1:0] dp_result
);

  localparam int N  = WIDTH / 2;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] CntLast = CW'(N - 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StRun  = 3'd2;
  localparam logic [2:0] StCapt = 3'd3;
  localparam logic [2:0] StHold = 3'd4;

  if (CHECK_PARAM == 1) begin : gen_check
    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : gen_bad_width
      $fatal(1, "radix4_booth_ctrl: WIDTH must be even and at least 2");
    end
  end

  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mr_q, mr_d;
  logic [WIDTH-1:0]   mc_q, mc_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mr_d    = mr_q;
    mc_d    = mc_q;
    res_d   = res_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          mr_d    = in_multiplier;
          mc_d    = in_multiplicand;
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        if (cnt_q == CntLast) begin
          state_d = StCapt;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCapt: begin
        res_d   = dp_result;
        state_d = StHold;
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mr_q    <= '0;
      mc_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mr_q    <= mr_d;
      mc_q    <= mc_d;
      res_q   <= res_d;
    end
  end

  // Outputs are gated by rst so an aborted operation never leaks a strobe or handshake.
  assign in_ready        = !rst && (state_q == StIdle);
  assign busy            = !rst && (state_q != StIdle);
  assign out_valid       = !rst && (state_q == StHold);
  assign dp_start        = !rst && (state_q == StLoad);
  assign dp_en           = !rst && (state_q == StRun);
  assign dp_rst_cntr_n   = !rst && (state_q != StLoad);
  assign out_result      = res_q;
  assign dp_multiplier   = mr_q;
  assign dp_multiplicand = mc_q;

endmodule

// File: tb/tb_radix4_booth_ctrl.sv
// Directed bench for radix4_booth_ctrl with a behavioural radix-4 Booth datapath attached.
module tb_radix4_booth_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  in_multiplier = 8'h00;
  logic [7:0]  in_multiplicand = 8'h00;
  logic        in_ready, out_valid, busy, dp_start, dp_en, dp_rst_cntr_n;
  logic [15:0] out_result;
  logic [7:0]  dp_multiplier, dp_multiplicand;
  logic [15:0] dp_result;

  int n_tests = 0;
  int n_fail  = 0;

  radix4_booth_ctrl #(.WIDTH(8), .CHECK_PARAM(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_multiplier   (in_multiplier),
    .in_multiplicand (in_multiplicand),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_result      (out_result),
    .busy            (busy),
    .dp_start        (dp_start),
    .dp_en           (dp_en),
    .dp_rst_cntr_n   (dp_rst_cntr_n),
    .dp_multiplier   (dp_multiplier),
    .dp_multiplicand (dp_multiplicand),
    .dp_result       (dp_result)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: one Booth digit per dp_en, so a wrong step count corrupts the product.
  logic [15:0] dp_acc = 16'h0000;
  int          dp_i = 0;
  assign dp_result = dp_acc;

  function automatic logic [15:0] booth_term(input logic [7:0] mr, input logic [7:0] mc,
                                             input int i);
    logic [31:0] mrx;
    int digit;
    int k;
    mrx   = {{24{mr[7]}}, mr};
    k     = (i > 7) ? 7 : i;
    digit = -2 * int'(mrx[2*k+1]) + int'(mrx[2*k]) + ((k == 0) ? 0 : int'(mrx[2*k-1]));
    return 16'((digit * int'($signed(mc))) <<< (2 * k));
  endfunction

  always @(posedge clk) begin
    if (!dp_rst_cntr_n) dp_i <= 0;
    else if (dp_en) dp_i <= dp_i + 1;
    if (dp_start) dp_acc <= 16'h0000;
    else if (dp_en) dp_acc <= dp_acc + booth_term(dp_multiplier, dp_multiplicand, dp_i);
  end

  // Free-running strobe monitor; tests compare deltas across one operation.
  int   cyc = 0, n_start = 0, n_en = 0, n_both = 0, n_clr = 0, en_first = 0, en_last = 0;
  logic en_prev = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dp_start) n_start <= n_start + 1;
    if (dp_en) begin
      n_en    <= n_en + 1;
      en_last <= cyc;
      if (!en_prev) en_first <= cyc;
    end
    en_prev <= dp_en;
    if (dp_start && dp_en) n_both <= n_both + 1;
    if (!rst && !dp_rst_cntr_n) n_clr <= n_clr + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offers one pair, returns once out_valid is high (or the bound expires) with its latency.
  task automatic start_op(input logic [7:0] mr, input logic [7:0] mc, output int lat);
    int guard;
    guard           = 0;
    in_multiplier   = mr;
    in_multiplicand = mc;
    in_valid        = 1'b1;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if ({dp_start, dp_en} !== 2'b00) begin n_fail++;
      $display("FAIL reset_strobes: got %b expected 00", {dp_start, dp_en}); end
    n_tests++; if (dp_rst_cntr_n !== 1'b0) begin n_fail++;
      $display("FAIL reset_cntr_n: got %b expected 0", dp_rst_cntr_n); end
    rst = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_tests++; if (dp_rst_cntr_n !== 1'b1) begin n_fail++;
      $display("FAIL reset_cntr_n_release: got %b expected 1", dp_rst_cntr_n); end
    n_tests++; if ({out_result, dp_multiplier, dp_multiplicand} !== 32'h0) begin n_fail++;
      $display("FAIL reset_regs: got %h expected 00000000",
               {out_result, dp_multiplier, dp_multiplicand}); end
  endtask

  task automatic test_products;
    logic [7:0]  mrs [4] = '{8'd3, 8'hF9, 8'h80, 8'h7F};
    logic [7:0]  mcs [4] = '{8'd5, 8'd9, 8'h80, 8'h80};
    logic [15:0] exps[4] = '{16'h000F, 16'hFFC1, 16'h4000, 16'hC080};
    int lat, s0, e0, b0, c0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s0 = n_start; e0 = n_en; b0 = n_both; c0 = n_clr;
      start_op(mrs[i], mcs[i], lat);
      n_tests++; if (lat !== 6) begin n_fail++;
        $display("FAIL latency[%0d]: got %0d expected 6", i, lat); end
      n_tests++; if (out_result !== exps[i]) begin n_fail++;
        $display("FAIL product[%0d]: got %h expected %h", i, out_result, exps[i]); end
      n_tests++; if (dp_multiplier !== mrs[i] || dp_multiplicand !== mcs[i]) begin n_fail++;
        $display("FAIL operands_held[%0d]: got %h/%h expected %h/%h", i, dp_multiplier,
                 dp_multiplicand, mrs[i], mcs[i]); end
      tick();
      n_tests++; if (n_start - s0 !== 1) begin n_fail++;
        $display("FAIL dp_start_count[%0d]: got %0d expected 1", i, n_start - s0); end
      n_tests++; if (n_en - e0 !== 4 || en_last - en_first !== 3) begin n_fail++;
        $display("FAIL dp_en_run[%0d]: got %0d cycles span %0d expected 4 span 3", i,
                 n_en - e0, en_last - en_first); end
      n_tests++; if (n_both - b0 !== 0) begin n_fail++;
        $display("FAIL start_en_overlap[%0d]: got %0d expected 0", i, n_both - b0); end
      n_tests++; if (n_clr - c0 !== 1) begin n_fail++;
        $display("FAIL cntr_clear_count[%0d]: got %0d expected 1", i, n_clr - c0); end
      n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++;
        $display("FAIL post_handshake[%0d]: got rdy=%b vld=%b expected rdy=1 vld=0", i,
                 in_ready, out_valid); end
    end
  endtask

  task automatic test_hold;
    int lat;
    out_ready = 1'b0;
    start_op(8'd6, 8'd7, lat);
    n_tests++; if (out_result !== 16'h002A) begin n_fail++;
      $display("FAIL hold_product: got %h expected 002a", out_result); end
    for (int c = 0; c < 10; c++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_result !== 16'h002A || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle[%0d]: got vld=%b res=%h rdy=%b expected vld=1 res=002a rdy=0",
                 c, out_valid, out_result, in_ready);
      end
    end
    out_ready = 1'b1;
    tick();
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++;
      $display("FAIL hold_release: got vld=%b rdy=%b expected vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_abort;
    int lat;
    logic saw_valid;
    out_ready       = 1'b1;
    in_multiplier   = 8'd5;
    in_multiplicand = 8'd9;
    in_valid        = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    n_tests++; if (dp_en !== 1'b1) begin n_fail++;
      $display("FAIL abort_in_run: got dp_en=%b expected 1", dp_en); end
    rst = 1'b1;
    tick();
    n_tests++; if ({dp_en, out_valid, busy} !== 3'b000) begin n_fail++;
      $display("FAIL abort_state: got en/vld/busy=%b expected 000", {dp_en, out_valid, busy}); end
    rst = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL abort_in_ready: got %b expected 1", in_ready); end
    saw_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    n_tests++; if (saw_valid !== 1'b0) begin n_fail++;
      $display("FAIL abort_no_valid: got %b expected 0", saw_valid); end
    start_op(8'd2, 8'd2, lat);
    n_tests++; if (out_result !== 16'h0004 || lat !== 6) begin n_fail++;
      $display("FAIL abort_recover: got %h lat %0d expected 0004 lat 6", out_result, lat); end
    tick();
  endtask

  task automatic test_back_to_back;
    int lat, guard;
    out_ready       = 1'b1;
    in_multiplier   = 8'd1;
    in_multiplicand = 8'd1;
    in_valid        = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    tick();
    in_multiplier   = 8'hFF;
    in_multiplicand = 8'd1;
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    n_tests++; if (out_result !== 16'h0001 || lat !== 6) begin n_fail++;
      $display("FAIL b2b_first: got %h lat %0d expected 0001 lat 6", out_result, lat); end
    n_tests++; if (dp_multiplier !== 8'd1) begin n_fail++;
      $display("FAIL b2b_ignored_offer: got %h expected 01", dp_multiplier); end
    tick();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL b2b_ready_after_hs: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_tests++; if (dp_start !== 1'b1 || dp_multiplier !== 8'hFF) begin n_fail++;
      $display("FAIL b2b_second_accept: got start=%b mr=%h expected start=1 mr=ff",
               dp_start, dp_multiplier); end
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    n_tests++; if (out_result !== 16'hFFFF || lat !== 6) begin n_fail++;
      $display("FAIL b2b_second: got %h lat %0d expected ffff lat 6", out_result, lat); end
    tick();
  endtask

  initial begin
    test_reset();
    test_products();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
